// File: rtl/prime_tick_tester_if.sv
// ---------------------------------------------------------------------------
// prime_tick_tester_if
//
// Purpose : Bundles the tick handshake and the result bus of the
//           prime_tick_tester block.
//
// Signals :
//   tick          advance request coming from the upstream tick divider
//   count_en      high while the tester is idle; feeds the divider's count
//   candidate     number under test, or the last number tested
//   is_prime      primality result for candidate, held between results
//   result_valid  one-cycle strobe marking a freshly posted result
//   busy          high while a test is in progress (CHECK, SUB, DONE)
//   overrun       sticky flag: a tick arrived while the tester was busy
//
// Modports:
//   master  upstream/consumer side (drives tick, observes the results)
//   slave   tester side (samples tick, drives the results)
// ---------------------------------------------------------------------------
interface prime_tick_tester_if #(
  parameter int WIDTH = 8
);

  logic             tick;
  logic             count_en;
  logic [WIDTH-1:0] candidate;
  logic             is_prime;
  logic             result_valid;
  logic             busy;
  logic             overrun;

  modport master (
    output tick,
    input  count_en,
    input  candidate,
    input  is_prime,
    input  result_valid,
    input  busy,
    input  overrun
  );

  modport slave (
    input  tick,
    output count_en,
    output candidate,
    output is_prime,
    output result_valid,
    output busy,
    output overrun
  );

endinterface : prime_tick_tester_if

// File: rtl/prime_tick_tester.sv
// ---------------------------------------------------------------------------
// prime_tick_tester
//
// Purpose : Each tick received while idle advances the candidate number by
//           one (wrapping at 2^WIDTH) and tests it for primality by trial
//           division, where each division is done by repeated subtraction,
//           one subtraction or compare per clock. count_en is low while a
//           test is running so the upstream divider pauses its ticks.
//
// Ports   :
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-high reset
//   bus     slave modport of prime_tick_tester_if
//             tick in; count_en, candidate, is_prime, result_valid,
//             busy, overrun out
//
// Parameters:
//   WIDTH   candidate width in bits (default 8)
// ---------------------------------------------------------------------------
module prime_tick_tester #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  prime_tick_tester_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_SUB   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0]   ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONE_W   = WIDTH'(1);
  localparam logic [WIDTH-1:0]   TWO_W   = WIDTH'(2);
  localparam logic [WIDTH-1:0]   THREE_W = WIDTH'(3);
  localparam logic [2*WIDTH-1:0] ONE_2W  = (2*WIDTH)'(1);

  state_e           state_q,     state_d;
  logic [WIDTH-1:0] candidate_q, candidate_d;
  logic             is_prime_q,  is_prime_d;
  logic [WIDTH-1:0] div_q,       div_d;
  logic [WIDTH-1:0] rem_q,       rem_d;
  logic             overrun_q,   overrun_d;

  // (d+1)^2 in double width so the square can never overflow; the divisor
  // stays small (about sqrt(2^WIDTH)+1), so a truncated product is exact.
  logic [2*WIDTH-1:0] div_inc_wide_s;
  logic [2*WIDTH-1:0] div_inc_sq_s;
  logic [2*WIDTH-1:0] candidate_wide_s;

  assign div_inc_wide_s   = {ZERO_W, div_q} + ONE_2W;
  assign div_inc_sq_s     = div_inc_wide_s * div_inc_wide_s;
  assign candidate_wide_s = {ZERO_W, candidate_q};

  // Next-state and datapath decode for the test sequencer.
  always_comb begin
    state_d     = state_q;
    candidate_d = candidate_q;
    is_prime_d  = is_prime_q;
    div_d       = div_q;
    rem_d       = rem_q;

    // Any tick outside IDLE is dropped and flagged until reset.
    if (bus.tick && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.tick) begin
          candidate_d = candidate_q + ONE_W;
          state_d     = ST_CHECK;
        end else begin
          state_d     = ST_IDLE;
        end
      end

      ST_CHECK: begin
        if (candidate_q < TWO_W) begin
          is_prime_d = 1'b0;
          state_d    = ST_DONE;
        end else if ((candidate_q == TWO_W) || (candidate_q == THREE_W)) begin
          is_prime_d = 1'b1;
          state_d    = ST_DONE;
        end else begin
          div_d      = TWO_W;
          rem_d      = candidate_q;
          state_d    = ST_SUB;
        end
      end

      ST_SUB: begin
        if (rem_q >= div_q) begin
          rem_d = rem_q - div_q;
        end else if (rem_q == ZERO_W) begin
          // Divisor found: candidate is composite.
          is_prime_d = 1'b0;
          state_d    = ST_DONE;
        end else if (div_inc_sq_s > candidate_wide_s) begin
          // Every divisor up to sqrt(candidate) left a remainder.
          is_prime_d = 1'b1;
          state_d    = ST_DONE;
        end else begin
          div_d = div_q + ONE_W;
          rem_d = candidate_q;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; reset also wins
  // over a tick sampled on the same edge and aborts any running test.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      candidate_q <= ZERO_W;
      is_prime_q  <= 1'b0;
      div_q       <= ZERO_W;
      rem_q       <= ZERO_W;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      candidate_q <= candidate_d;
      is_prime_q  <= is_prime_d;
      div_q       <= div_d;
      rem_q       <= rem_d;
      overrun_q   <= overrun_d;
    end
  end

  // Outputs are either registers or pure decodes of the state register.
  assign bus.count_en     = (state_q == ST_IDLE);
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.result_valid = (state_q == ST_DONE);
  assign bus.candidate    = candidate_q;
  assign bus.is_prime     = is_prime_q;
  assign bus.overrun      = overrun_q;

endmodule : prime_tick_tester

// File: tb/tb_prime_tick_tester.sv
// ---------------------------------------------------------------------------
// tb_prime_tick_tester
//
// Purpose : Drives prime_tick_tester like the upstream divider would (ticks
//           only while count_en is high, random idle gaps) and compares each
//           result against a plain-arithmetic primality and latency model.
// ---------------------------------------------------------------------------
module tb_prime_tick_tester;

  localparam int WIDTH = 8;
  localparam int MAXV  = (1 << WIDTH);

  logic clk = 1'b0;
  logic reset;

  int checks   = 0;
  int failures = 0;
  int exp_cand = 0;
  int exp_ovr  = 0;

  prime_tick_tester_if #(.WIDTH(WIDTH)) bus ();

  prime_tick_tester #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  // Bounds the whole run in case the DUT stops responding.
  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s cand=%0d got=%0d exp=%0d", tag, exp_cand, got, exp);
    end
  endtask

  function automatic int ref_prime(input int n);
    if (n < 2) return 0;
    for (int d = 2; d * d <= n; d++) begin
      if (n % d == 0) return 0;
    end
    return 1;
  endfunction

  // Edges from the tick edge to the edge that enters the result cycle:
  // two for CHECK, then for each divisor tried, n/d subtractions and one
  // compare; trial stops at the first divisor or once (d+1)^2 exceeds n.
  function automatic int ref_latency(input int n);
    int cyc;
    if (n < 4) return 2;
    cyc = 0;
    for (int d = 2; d <= n; d++) begin
      cyc += (n / d) + 1;
      if (n % d == 0) break;
      if ((d + 1) * (d + 1) > n) break;
    end
    return 2 + cyc;
  endfunction

  // Waits for count_en (bounded), issues one tick after a random gap, and
  // checks the resulting strobe, value and timing. A non-zero extra_at
  // fires a second, illegal tick after that many edges.
  task automatic run_test(input int extra_at);
    int  n;
    int  k;
    int  lat;
    int  en_bad;
    bit  seen;
    n = 0;
    while (bus.count_en !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_val("ready", int'(bus.count_en), 1);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    exp_cand = (exp_cand + 1) % MAXV;
    bus.tick = 1'b1;
    seen   = 1'b0;
    lat    = 0;
    en_bad = 0;
    k      = 0;
    while (!seen && k < 2000) begin
      @(negedge clk);
      k++;
      bus.tick = 1'b0;
      if (bus.result_valid === 1'b1) begin
        seen = 1'b1;
        lat  = k;
      end else if (bus.count_en !== 1'b0 || bus.busy !== 1'b1) begin
        en_bad++;
      end
      if (k == extra_at && !seen) begin
        check_val("ovr_busy", int'(bus.busy), 1);
        bus.tick = 1'b1;
        exp_ovr  = 1;
      end
    end
    check_val("valid_seen", int'(seen), 1);
    check_val("latency", lat, ref_latency(exp_cand));
    check_val("is_prime", int'(bus.is_prime), ref_prime(exp_cand));
    check_val("candidate", int'(bus.candidate), exp_cand);
    check_val("busy_done", int'(bus.busy), 1);
    check_val("en_done", int'(bus.count_en), 0);
    check_val("en_low", en_bad, 0);
    check_val("overrun", int'(bus.overrun), exp_ovr);
    @(negedge clk);
    check_val("valid_pulse", int'(bus.result_valid), 0);
    check_val("en_after", int'(bus.count_en), 1);
    check_val("prime_hold", int'(bus.is_prime), ref_prime(exp_cand));
    check_val("cand_hold", int'(bus.candidate), exp_cand);
  endtask

  initial begin
    int n;
    int pulses;
    reset    = 1'b1;
    bus.tick = 1'b0;

    // Reset values after two reset edges.
    repeat (2) @(negedge clk);
    check_val("rst_candidate", int'(bus.candidate), 0);
    check_val("rst_is_prime", int'(bus.is_prime), 0);
    check_val("rst_valid", int'(bus.result_valid), 0);
    check_val("rst_busy", int'(bus.busy), 0);
    check_val("rst_overrun", int'(bus.overrun), 0);
    check_val("rst_count_en", int'(bus.count_en), 1);
    reset = 1'b0;

    // 1..255 then wrap to 0, ticking only while count_en is high.
    for (int i = 1; i <= MAXV; i++) begin
      run_test(0);
    end

    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    exp_cand = 0;
    exp_ovr  = 0;

    // Overrun: second tick two edges into the test of 9.
    for (int i = 1; i <= 8; i++) run_test(0);
    run_test(2);
    for (int i = 10; i <= 120; i++) run_test(0);

    // Reset in the middle of testing 121.
    n = 0;
    while (bus.count_en !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    exp_cand = 121;
    bus.tick = 1'b1;
    pulses   = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.tick = 1'b0;
      if (bus.result_valid === 1'b1) pulses++;
    end
    check_val("abort_busy", int'(bus.busy), 1);
    check_val("abort_cand", int'(bus.candidate), 121);
    // Tick alongside reset: reset must win.
    reset    = 1'b1;
    bus.tick = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    bus.tick = 1'b0;
    if (bus.result_valid === 1'b1) pulses++;
    check_val("abort_pulses", pulses, 0);
    check_val("abort_rst_cand", int'(bus.candidate), 0);
    check_val("abort_count_en", int'(bus.count_en), 1);
    check_val("abort_busy_clr", int'(bus.busy), 0);
    check_val("abort_overrun", int'(bus.overrun), 0);
    exp_cand = 0;
    exp_ovr  = 0;
    run_test(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_prime_tick_tester

// File: doc/prime_tick_tester.md
# prime_tick_tester

Downstream consumer of the tick-divider stage: each one-cycle `tick` pulse advances an internal candidate number by one and tests it for primality by iterative trial division using repeated subtraction. While a test is in progress, the block deasserts `count_en`, which drives the upstream divider's `count` input, so ticks pause until the result is posted. Results are reported as a one-cycle `result_valid` strobe, with a held `is_prime` flag and the tested `candidate`.

## Interface

- `WIDTH`, default 8: candidate width in bits; candidates run from 0 to 2^WIDTH-1.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `tick`  in  1  advance request (upstream `timeOut`); sampled only in IDLE.
- `count_en`  out  1  high exactly when the state is IDLE; drives the upstream `count`.
- `candidate`  out  WIDTH  number currently being tested, or last tested.
- `is_prime`  out  1  result for `candidate`; held until the next DONE.
- `result_valid`  out  1  high for exactly the one cycle spent in DONE.
- `busy`  out  1  high in CHECK, SUB and DONE.
- `overrun`  out  1  sticky; set when `tick`=1 in any state other than IDLE; cleared only by reset.

## Operation

- **States:** IDLE, CHECK, SUB, DONE. All outputs are registered or decoded from state.
- **Internal registers:**
  - `d` (WIDTH bits): trial divisor.
  - `rem` (WIDTH bits): running remainder.
- **IDLE:**
  - `tick`=1: `candidate <= candidate+1` (mod 2^WIDTH; 2^WIDTH-1 wraps to 0), then go to CHECK.
  - `tick`=0: stay in IDLE.
- **CHECK:**
  - `candidate` < 2: `is_prime <= 0`, go to DONE.
  - `candidate` is 2 or 3: `is_prime <= 1`, go to DONE.
  - Otherwise: `d <= 2`, `rem <= candidate`, go to SUB.
- **SUB** (one action per cycle):
  - `rem >= d`: `rem <= rem - d`.
  - `rem < d` and `rem == 0`: `is_prime <= 0`, go to DONE.
  - `rem < d` and `rem != 0`:
    - If `(d+1)*(d+1) > candidate`: `is_prime <= 1`, go to DONE.
    - Else: `d <= d+1`, `rem <= candidate`.
- **Arithmetic:** the square is computed in 2*WIDTH bits, so it never overflows. `d` never exceeds floor(sqrt(2^WIDTH-1))+1.
- **DONE:** `result_valid`=1 for this cycle only, then go to IDLE unconditionally.
- **Ticks outside IDLE:** ignored, `candidate` unchanged, `overrun` set.
- **Reset:**
  - Values: state IDLE, `candidate`=0, `is_prime`=0, `result_valid`=0, `busy`=0, `overrun`=0, `d`=0, `rem`=0.
  - `count_en` is 1 from the cycle after the reset edge.
  - Reset asserted mid-test aborts the test with no `result_valid` pulse.
  - Reset takes priority over `tick` in the same cycle.

## Timing

- Edges are counted from the edge that samples `tick`=1 in IDLE (edge 1).
- **Trivial candidates (0–3):**
  - Edge 1 enters CHECK; edge 2 enters DONE.
  - `result_valid` is high in the cycle after edge 2.
  - Back in IDLE after edge 3, with `count_en`=1 in that cycle.
- **General latency:** tick-to-valid = 2 + (number of SUB cycles) edges.
  - Each divisor `d` costs floor(`candidate`/d) subtract cycles plus one compare cycle.
- **Worked values:**
  - `candidate`=4: 2 subtracts + 1 compare, valid after edge 5.
  - `candidate`=5: 2 subtracts + 1 compare, prime, valid after edge 5.
- **`count_en`:** low from the cycle after edge 1 through the DONE cycle inclusive.
- **Holds:** `is_prime` and `candidate` are stable from DONE until the next CHECK/SUB update. `is_prime` changes only on the entry to DONE.

## Test plan

- **Reset values:** hold `reset`=1 for 2 cycles -> `candidate`=0, `is_prime`=0, `result_valid`=0, `busy`=0, `overrun`=0, `count_en`=1.
- **Sequence from reset:** 11 ticks, each issued only when `count_en`=1.
  - Results for 1..11 -> `is_prime` = 0,1,1,0,1,0,1,0,0,0,1.
  - Exactly one `result_valid` pulse per tick.
  - `candidate`=2 valid 2 edges after its tick; `candidate`=4 valid 5 edges after its tick.
- **Wrap-around (WIDTH=8):** preload by ticking to 251 -> prime. Then 252..255 -> 0,0,0,0 (255 = 3·5·17). Next tick gives `candidate`=0 -> `is_prime`=0.
- **Overrun:** tick at `candidate`=9 and again 2 cycles later while `busy`=1 -> second tick ignored, `candidate` stays 9, `overrun`=1 and stays 1 through later results.
- **Reset mid-test:** assert `reset` during SUB of `candidate`=121 -> no `result_valid`. Next cycle `candidate`=0 and `count_en`=1. A following tick tests 1 -> `is_prime`=0.
- **Upstream loop:** connect the upstream divider to `count_en`/`tick` and run 20 results -> ticks never arrive while `busy`=1, `overrun` remains 0, and the results match a reference prime list.
